instr_mem_banked: RTL and testbench
===================================

// Module: instr_mem_banked
// PURPOSE
// Parametrised, banked instruction store for the pipelined CPU fetch stage. Replaces the hard-coded
// combinational instruction ROM: registered 1-cycle fetch with stall hold, PC base offset, halt-on-out-of-range,
// and a streaming loader that writes a program into one bank while the other bank keeps serving fetches.
// PARAMETERS
// OPC_W      5            opcode field width
// ARG_W      4            operand field width; INSTR_W = OPC_W+ARG_W (default 9)
// PC_W       16           program counter width
// DEPTH      256          instruction words per bank (power of 2, >=2)
// BANKS      2            number of program banks (>=1); BANK_W = max(1,$clog2(BANKS))
// BASE_ADDR  0            PC value mapped to word 0 of every bank
// HALT_OPC   5'b11010     opcode returned for empty/out-of-range/unloaded words
// PORTS
// clk          in   1        clock, all state on rising edge
// rst_n        in   1        asynchronous active-low reset
// fetch_req    in   1        fetch request this cycle
// fetch_pc     in   PC_W     program counter to fetch
// fetch_bank   in   BANK_W   bank to fetch from
// fetch_stall  in   1        hold current instruction output
// instruction  out  INSTR_W  fetched word {opcode, operand}
// instr_valid  out  1        instruction holds a valid fetch result
// instr_oob    out  1        fetched PC outside [BASE_ADDR, BASE_ADDR+DEPTH-1]
// ld_start     in   1        begin loading bank ld_bank (pulse)
// ld_bank      in   BANK_W   target bank, sampled with ld_start
// ld_valid     in   1        ld_data valid this cycle
// ld_data      in   INSTR_W  program word
// ld_last      in   1        qualifies final ld_valid word
// ld_ready     out  1        loader accepts ld_data (high only in LOAD)
// ld_busy      out  1        loader not IDLE
// ld_done      out  1        one-cycle pulse when load+fill complete
// ld_count     out  $clog2(DEPTH)+1  words accepted in current/last load
// BEHAVIOUR
// - Reset: instruction={HALT_OPC,0}, instr_valid=0, instr_oob=0, ld_ready=0, ld_busy=0, ld_done=0,
//   ld_count=0, FSM=IDLE, all per-bank loaded flags=0. RAM contents not reset.
// - Fetch: idx = fetch_pc - BASE_ADDR (PC_W-bit unsigned). oob = fetch_pc<BASE_ADDR || idx>=DEPTH.
//   fetch_req & !fetch_stall -> next cycle: instr_valid=1, instr_oob=oob, instruction = RAM word, or
//   {HALT_OPC,0} if oob or bank not loaded. Latency exactly 1 cycle.
// - fetch_stall=1: instruction/instr_valid/instr_oob held unchanged; fetch_req ignored (stall wins).
// - !fetch_req & !fetch_stall: instr_valid->0, instruction holds last value.
// - Fetch to bank currently being loaded (ld_busy & fetch_bank==load bank): instr_valid=0 next cycle.
// - Loader FSM IDLE->LOAD->FILL->IDLE:
//   IDLE: ld_start -> latch bank, clear its loaded flag, ld_count=0, go LOAD. ld_valid ignored.
//   LOAD: ld_ready=1; each ld_valid writes ld_data at word ld_count, ld_count++.
//     ld_valid&ld_last, or word DEPTH-1 written -> FILL (ld_ready drops the following cycle).
//   FILL: writes {HALT_OPC,0} to words ld_count..DEPTH-1, one per cycle; if none remain, zero cycles.
//     On completion: set loaded flag, ld_done=1 for one cycle, go IDLE. ld_count keeps final value.
// - ld_start while ld_busy: ignored. ld_last without ld_valid: ignored.
// - Fetch read and loader write to different banks in the same cycle: both proceed.
// - rst_n low mid-load: immediate return to IDLE, all loaded flags cleared, no ld_done.
// STRUCTURE
// - instr_pkg: OPC_W/ARG_W defaults, opcode constants (add..halt, HALT_OPC), halt word helper.
// - Sub-module instr_mem_bank: DEPTH x INSTR_W 1R1W synchronous RAM, instantiated BANKS times
//   (generate). Top holds fetch output register, address translation, loaded flags, loader FSM.
// TESTING
// - Reset, then fetch bank0 pc=0 -> instr_valid=1, instruction=9'b11010_0000 (unloaded), instr_oob=0.
// - Load bank0 words 0x00A,0x0B1,0x1D0 (ld_last on 3rd) -> ld_done 1 cycle after FILL of DEPTH-3 words;
//   fetch pc=1 -> 0x0B1 one cycle later; pc=3 -> 9'h1A0 (halt fill).
// - BASE_ADDR=4: fetch pc=3 -> halt, instr_oob=1; pc=4 -> word0; pc=4+DEPTH -> instr_oob=1.
// - fetch_stall held 3 cycles while fetch_pc changes -> instruction constant; release -> new word next cycle.
// - Load bank1 while fetching bank0 each cycle -> bank0 fetches valid; bank1 fetch -> instr_valid=0 until ld_done.
// - Stream DEPTH words with no ld_last -> auto-terminate, ld_count=DEPTH, FILL 0 cycles; rst_n pulse mid-load
//   -> ld_busy=0, bank unloaded (fetch returns halt).

Source files
------------

// File: rtl/instr_pkg.sv
// ----------------------------------------------------------------------------
// instr_pkg : shared instruction-format constants, opcodes and loader states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package instr_pkg;

   localparam int DEF_OPC_W = 5;
   localparam int DEF_ARG_W = 4;

   localparam logic [DEF_OPC_W-1:0] OPC_ADD  = 5'b00000;
   localparam logic [DEF_OPC_W-1:0] OPC_SUB  = 5'b00001;
   localparam logic [DEF_OPC_W-1:0] OPC_AND  = 5'b00010;
   localparam logic [DEF_OPC_W-1:0] OPC_OR   = 5'b00011;
   localparam logic [DEF_OPC_W-1:0] OPC_XOR  = 5'b00100;
   localparam logic [DEF_OPC_W-1:0] OPC_LD   = 5'b01000;
   localparam logic [DEF_OPC_W-1:0] OPC_ST   = 5'b01001;
   localparam logic [DEF_OPC_W-1:0] OPC_JMP  = 5'b10000;
   localparam logic [DEF_OPC_W-1:0] OPC_BEQ  = 5'b10001;
   localparam logic [DEF_OPC_W-1:0] OPC_HALT = 5'b11010;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_LOAD = 2'd1,
      LD_FILL = 2'd2
   } ld_state_e;

   function automatic logic [DEF_OPC_W+DEF_ARG_W-1:0] halt_word();
      return {OPC_HALT, {DEF_ARG_W{1'b0}}};
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_mem_bank.sv
// ----------------------------------------------------------------------------
// instr_mem_bank : DEPTH x WIDTH 1R1W synchronous RAM, read register held
//                  while the read enable is low
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_mem_bank #(
   parameter int DEPTH  = 256,
   parameter int WIDTH  = 9,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

`default_nettype wire

// File: rtl/instr_mem_banked.sv
// ----------------------------------------------------------------------------
// instr_mem_banked : banked instruction store, 1-cycle registered fetch with
//                    stall hold, plus a streaming loader with halt fill
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_mem_banked
   import instr_pkg::*;
#(
   parameter int OPC_W     = DEF_OPC_W,
   parameter int ARG_W     = DEF_ARG_W,
   parameter int PC_W      = 16,
   parameter int DEPTH     = 256,
   parameter int BANKS     = 2,
   parameter int BASE_ADDR = 0,
   parameter logic [OPC_W-1:0] HALT_OPC = OPC_HALT,
   localparam int INSTR_W  = OPC_W + ARG_W,
   localparam int BANK_W   = (BANKS > 1) ? $clog2(BANKS) : 1,
   localparam int CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fetch_req,
   input  logic [PC_W-1:0]    fetch_pc,
   input  logic [BANK_W-1:0]  fetch_bank,
   input  logic               fetch_stall,
   output logic [INSTR_W-1:0] instruction,
   output logic               instr_valid,
   output logic               instr_oob,
   input  logic               ld_start,
   input  logic [BANK_W-1:0]  ld_bank,
   input  logic               ld_valid,
   input  logic [INSTR_W-1:0] ld_data,
   input  logic               ld_last,
   output logic               ld_ready,
   output logic               ld_busy,
   output logic               ld_done,
   output logic [CNT_W-1:0]   ld_count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [INSTR_W-1:0] HALT_WORD = {HALT_OPC, {ARG_W{1'b0}}};

   ld_state_e          state_q;
   logic [BANK_W-1:0]  ld_bank_q;
   logic [CNT_W-1:0]   ld_count_q;
   logic [IDX_W-1:0]   fill_q;
   logic               ld_ready_q, ld_busy_q, ld_done_q;
   logic [BANKS-1:0]   loaded_q;

   logic               valid_q, oob_q, halt_q;
   logic [BANK_W-1:0]  bank_q;

   logic [PC_W-1:0]    w_idx;
   logic               w_oob, w_take, w_loaded, w_busy_hit;
   logic               w_we;
   logic [IDX_W-1:0]   w_waddr;
   logic [INSTR_W-1:0] w_wdata, w_rd_sel;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [INSTR_W-1:0] w_rdata [BANKS];

   // Unsigned wrap of the subtraction is harmless: pc < base is flagged separately.
   assign w_idx      = fetch_pc - PC_W'(BASE_ADDR);
   assign w_oob      = (fetch_pc < PC_W'(BASE_ADDR)) || (32'(w_idx) >= 32'(DEPTH));
   assign w_take     = fetch_req && !fetch_stall;
   assign w_busy_hit = ld_busy_q && (fetch_bank == ld_bank_q);

   always_comb begin
      w_loaded = 1'b0;
      w_rd_sel = HALT_WORD;
      for (int b = 0; b < BANKS; b++) begin
         if (fetch_bank == BANK_W'(b)) w_loaded = loaded_q[b];
         if (bank_q == BANK_W'(b))     w_rd_sel = w_rdata[b];
      end
   end

   assign w_we      = ((state_q == LD_LOAD) && ld_valid) || (state_q == LD_FILL);
   assign w_waddr   = (state_q == LD_FILL) ? fill_q : ld_count_q[IDX_W-1:0];
   assign w_wdata   = (state_q == LD_FILL) ? HALT_WORD : ld_data;
   assign w_cnt_inc = ld_count_q + 1'b1;

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      instr_mem_bank #(
         .DEPTH (DEPTH),
         .WIDTH (INSTR_W)
      ) u_bank (
         .clk     (clk),
         .we_i    (w_we && (ld_bank_q == BANK_W'(b))),
         .waddr_i (w_waddr),
         .wdata_i (w_wdata),
         .re_i    (w_take && (fetch_bank == BANK_W'(b))),
         .raddr_i (w_idx[IDX_W-1:0]),
         .rdata_o (w_rdata[b])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         oob_q   <= 1'b0;
         halt_q  <= 1'b1;
         bank_q  <= '0;
      end else if (w_take) begin
         valid_q <= !w_busy_hit;
         oob_q   <= w_oob;
         halt_q  <= w_oob || !w_loaded;
         bank_q  <= fetch_bank;
      end else if (!fetch_stall) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= LD_IDLE;
         ld_bank_q  <= '0;
         ld_count_q <= '0;
         fill_q     <= '0;
         ld_ready_q <= 1'b0;
         ld_busy_q  <= 1'b0;
         ld_done_q  <= 1'b0;
         loaded_q   <= '0;
      end else begin
         ld_done_q <= 1'b0;
         case (state_q)
            LD_IDLE: begin
               if (ld_start) begin
                  ld_bank_q  <= ld_bank;
                  ld_count_q <= '0;
                  ld_ready_q <= 1'b1;
                  ld_busy_q  <= 1'b1;
                  state_q    <= LD_LOAD;
                  for (int b = 0; b < BANKS; b++)
                     if (ld_bank == BANK_W'(b)) loaded_q[b] <= 1'b0;
               end
            end
            LD_LOAD: begin
               if (ld_valid) begin
                  ld_count_q <= w_cnt_inc;
                  // A full bank leaves nothing to fill, so completion is immediate.
                  if (ld_count_q == CNT_W'(DEPTH - 1)) begin
                     ld_ready_q <= 1'b0;
                     ld_busy_q  <= 1'b0;
                     ld_done_q  <= 1'b1;
                     state_q    <= LD_IDLE;
                     for (int b = 0; b < BANKS; b++)
                        if (ld_bank_q == BANK_W'(b)) loaded_q[b] <= 1'b1;
                  end else if (ld_last) begin
                     ld_ready_q <= 1'b0;
                     fill_q     <= w_cnt_inc[IDX_W-1:0];
                     state_q    <= LD_FILL;
                  end
               end
            end
            LD_FILL: begin
               fill_q <= fill_q + 1'b1;
               if (fill_q == IDX_W'(DEPTH - 1)) begin
                  ld_busy_q <= 1'b0;
                  ld_done_q <= 1'b1;
                  state_q   <= LD_IDLE;
                  for (int b = 0; b < BANKS; b++)
                     if (ld_bank_q == BANK_W'(b)) loaded_q[b] <= 1'b1;
               end
            end
            default: state_q <= LD_IDLE;
         endcase
      end
   end

   assign instruction = halt_q ? HALT_WORD : w_rd_sel;
   assign instr_valid = valid_q;
   assign instr_oob   = oob_q;
   assign ld_ready    = ld_ready_q;
   assign ld_busy     = ld_busy_q;
   assign ld_done     = ld_done_q;
   assign ld_count    = ld_count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_banked.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_banked : self-checking bench, two instances (base 0 and base 4)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instr_mem_banked;
   import instr_pkg::*;

   localparam int DEPTH = 16;
   localparam int BANKS = 2;
   localparam int BASE_B = 4;
   localparam logic [8:0] HW = 9'h1A0;

   logic        clk;
   logic        rst_n;
   logic        fetch_req, fetch_stall;
   logic [15:0] fetch_pc;
   logic [0:0]  fetch_bank;
   logic        ld_start, ld_valid, ld_last;
   logic [0:0]  ld_bank;
   logic [8:0]  ld_data;

   logic [8:0]  instr_a, instr_b;
   logic        valid_a, valid_b, oob_a, oob_b;
   logic        rdy_a, rdy_b, busy_a, busy_b, done_a, done_b;
   logic [4:0]  cnt_a, cnt_b;

   instr_mem_banked #(.DEPTH(DEPTH), .BANKS(BANKS), .BASE_ADDR(0)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_bank(fetch_bank), .fetch_stall(fetch_stall),
      .instruction(instr_a), .instr_valid(valid_a), .instr_oob(oob_a),
      .ld_start(ld_start), .ld_bank(ld_bank), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(rdy_a), .ld_busy(busy_a), .ld_done(done_a), .ld_count(cnt_a)
   );

   instr_mem_banked #(.DEPTH(DEPTH), .BANKS(BANKS), .BASE_ADDR(BASE_B)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_bank(fetch_bank), .fetch_stall(fetch_stall),
      .instruction(instr_b), .instr_valid(valid_b), .instr_oob(oob_b),
      .ld_start(ld_start), .ld_bank(ld_bank), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(rdy_b), .ld_busy(busy_b), .ld_done(done_b), .ld_count(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: program image per bank, loaded flags, and a loader
   // described by the cycle at which its halt fill finishes.
   logic [8:0] m_mem [BANKS][DEPTH];
   bit         m_loaded [BANKS];
   bit         m_busy, m_ready, m_done;
   int         m_bank, m_count, m_fin, ncyc;
   logic [8:0] e_instr [2];
   bit         e_valid [2], e_oob [2], e_known [2];

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] pc;
      logic [8:0]  ia;
      logic        oa;
      logic [8:0]  ib;
      logic        ob;
   } vec_t;
   vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_ready = 0; m_done = 0; m_count = 0; m_fin = -1;
      for (int b = 0; b < BANKS; b++) m_loaded[b] = 0;
      for (int d = 0; d < 2; d++) begin
         e_instr[d] = HW; e_valid[d] = 0; e_oob[d] = 0; e_known[d] = 1;
      end
   endtask

   task automatic model_edge();
      int idx;
      if (!fetch_stall) begin
         for (int d = 0; d < 2; d++) begin
            if (fetch_req) begin
               idx = int'(fetch_pc) - (d == 1 ? BASE_B : 0);
               e_oob[d]   = (idx < 0) || (idx >= DEPTH);
               e_valid[d] = !(m_busy && int'(fetch_bank) == m_bank);
               e_known[d] = e_valid[d];
               if (e_oob[d] || !m_loaded[fetch_bank]) e_instr[d] = HW;
               else e_instr[d] = m_mem[fetch_bank][idx];
            end else begin
               e_valid[d] = 0;
            end
         end
      end
      m_done = 0;
      if (m_busy && !m_ready) begin
         if (ncyc == m_fin) begin
            m_loaded[m_bank] = 1; m_busy = 0; m_done = 1;
         end
      end else if (m_busy) begin
         if (ld_valid) begin
            m_mem[m_bank][m_count] = ld_data;
            m_count++;
            if (ld_last || m_count == DEPTH) begin
               for (int i = m_count; i < DEPTH; i++) m_mem[m_bank][i] = HW;
               m_ready = 0;
               if (m_count == DEPTH) begin
                  m_loaded[m_bank] = 1; m_busy = 0; m_done = 1;
               end else begin
                  m_fin = ncyc + DEPTH - m_count;
               end
            end
         end
      end else if (ld_start) begin
         m_bank = int'(ld_bank); m_loaded[m_bank] = 0; m_count = 0;
         m_busy = 1; m_ready = 1;
      end
      ncyc++;
   endtask

   task automatic chk_fetch(input string tag, input int d, input logic [8:0] ins, input logic v, input logic o);
      chk({tag, "_valid"}, 32'(v), 32'(e_valid[d]));
      if (e_known[d]) chk({tag, "_instr"}, 32'(ins), 32'(e_instr[d]));
      if (e_valid[d]) chk({tag, "_oob"}, 32'(o), 32'(e_oob[d]));
   endtask

   task automatic check_all();
      chk_fetch("a", 0, instr_a, valid_a, oob_a);
      chk_fetch("b", 1, instr_b, valid_b, oob_b);
      chk("ld_ready", 32'(rdy_a), 32'(m_ready));
      chk("ld_busy", 32'(busy_a), 32'(m_busy));
      chk("ld_done", 32'(done_a), 32'(m_done));
      chk("ld_count", 32'(cnt_a), 32'(m_count));
      chk("b_ld_ifc", {26'd0, rdy_b, busy_b, done_b, cnt_b[2:0]}, {26'd0, rdy_a, busy_a, done_a, cnt_a[2:0]});
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle_ld();
      ld_start = 0; ld_valid = 0; ld_last = 0;
   endtask

   initial begin
      int n;
      logic [8:0] words [3];
      words[0] = 9'h00A; words[1] = 9'h0B1; words[2] = 9'h1D0;

      tbl[0]  = '{16'd0,  9'h00A, 1'b0, HW,     1'b1};
      tbl[1]  = '{16'd1,  9'h0B1, 1'b0, HW,     1'b1};
      tbl[2]  = '{16'd2,  9'h1D0, 1'b0, HW,     1'b1};
      tbl[3]  = '{16'd3,  HW,     1'b0, HW,     1'b1};
      tbl[4]  = '{16'd4,  HW,     1'b0, 9'h00A, 1'b0};
      tbl[5]  = '{16'd5,  HW,     1'b0, 9'h0B1, 1'b0};
      tbl[6]  = '{16'd6,  HW,     1'b0, 9'h1D0, 1'b0};
      tbl[7]  = '{16'd15, HW,     1'b0, HW,     1'b0};
      tbl[8]  = '{16'd16, HW,     1'b1, HW,     1'b0};
      tbl[9]  = '{16'd19, HW,     1'b1, HW,     1'b0};
      tbl[10] = '{16'd20, HW,     1'b1, HW,     1'b1};

      rst_n = 0; fetch_req = 0; fetch_stall = 0; fetch_pc = '0; fetch_bank = '0;
      ld_bank = '0; ld_data = '0; idle_ld();
      ncyc = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_all();
      chk("reset_instr", 32'(instr_a), 32'(HW));
      chk("reset_valid", 32'(valid_a), 32'd0);
      chk("reset_count", 32'(cnt_a), 32'd0);
      rst_n = 1;

      // Unloaded bank fetch returns the halt word.
      fetch_req = 1; fetch_pc = 16'd0; fetch_bank = 1'b0;
      cyc();
      chk("unloaded_valid", 32'(valid_a), 32'd1);
      chk("unloaded_instr", 32'(instr_a), 32'h1A0);
      chk("unloaded_oob", 32'(oob_a), 32'd0);
      fetch_req = 0;

      // Short program into bank0, then halt fill.
      ld_start = 1; ld_bank = 1'b0;
      cyc();
      ld_start = 0;
      chk("ld_ready_up", 32'(rdy_a), 32'd1);
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1; ld_data = words[i]; ld_last = (i == 2);
         cyc();
      end
      idle_ld();
      n = 0;
      while (!done_a && n < 100) begin cyc(); n++; end
      chk("fill_cycles", 32'(n), 32'(DEPTH - 3));
      chk("fill_count", 32'(cnt_a), 32'd3);
      cyc();

      for (int i = 0; i < 11; i++) begin
         fetch_req = 1; fetch_bank = 1'b0; fetch_pc = tbl[i].pc;
         cyc();
         chk("tbl_a_instr", 32'(instr_a), 32'(tbl[i].ia));
         chk("tbl_a_oob", 32'(oob_a), 32'(tbl[i].oa));
         chk("tbl_b_instr", 32'(instr_b), 32'(tbl[i].ib));
         chk("tbl_b_oob", 32'(oob_b), 32'(tbl[i].ob));
         chk("tbl_valid", 32'(valid_a), 32'd1);
      end

      // Stall holds the output while the PC moves.
      fetch_pc = 16'd1;
      cyc();
      fetch_stall = 1;
      for (int k = 0; k < 3; k++) begin
         fetch_pc = 16'(2 + k);
         cyc();
         chk("stall_hold", 32'(instr_a), 32'h0B1);
      end
      fetch_stall = 0; fetch_pc = 16'd2;
      cyc();
      chk("stall_release", 32'(instr_a), 32'h1D0);
      fetch_req = 0;
      cyc();
      chk("noreq_valid", 32'(valid_a), 32'd0);
      chk("noreq_hold", 32'(instr_a), 32'h1D0);

      // Load bank1 while bank0 keeps fetching.
      fetch_req = 1; fetch_bank = 1'b0; fetch_pc = 16'd0;
      ld_start = 1; ld_bank = 1'b1;
      cyc();
      ld_start = 0;
      for (int i = 0; i < 5; i++) begin
         ld_valid = 1; ld_data = 9'($urandom); ld_last = (i == 4); fetch_pc = 16'(i);
         cyc();
         chk("bank0_during_load", 32'(valid_a), 32'd1);
      end
      idle_ld();
      fetch_bank = 1'b1;
      n = 0;
      while (!done_a && n < 100) begin
         cyc();
         chk("bank1_busy_invalid", 32'(valid_a), 32'd0);
         n++;
      end
      chk("bank1_fill_cycles", 32'(n), 32'(DEPTH - 5));
      cyc();
      chk("bank1_after_done", 32'(valid_a), 32'd1);

      // Full-depth stream with no ld_last terminates by itself.
      fetch_req = 0;
      ld_start = 1; ld_bank = 1'b1;
      cyc();
      ld_start = 0;
      for (int i = 0; i < DEPTH; i++) begin
         ld_valid = 1; ld_data = 9'($urandom); ld_last = 0;
         cyc();
      end
      idle_ld();
      chk("full_done", 32'(done_a), 32'd1);
      chk("full_count", 32'(cnt_a), 32'(DEPTH));
      chk("full_busy", 32'(busy_a), 32'd0);
      cyc();

      // Reset in the middle of a load.
      ld_start = 1; ld_bank = 1'b0;
      cyc();
      ld_start = 0;
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1; ld_data = 9'($urandom);
         cyc();
      end
      idle_ld();
      rst_n = 0;
      #1;
      model_reset();
      check_all();
      chk("midrst_busy", 32'(busy_a), 32'd0);
      #2 rst_n = 1;
      fetch_req = 1; fetch_bank = 1'b0; fetch_pc = 16'd1;
      cyc();
      chk("midrst_bank0_halt", 32'(instr_a), 32'(HW));
      fetch_bank = 1'b1;
      cyc();
      chk("midrst_bank1_halt", 32'(instr_a), 32'(HW));

      // Randomised traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         fetch_req   = ($urandom_range(0, 3) != 0);
         fetch_stall = ($urandom_range(0, 4) == 0);
         fetch_pc    = 16'($urandom_range(0, 24));
         fetch_bank  = 1'($urandom_range(0, 1));
         ld_start    = ($urandom_range(0, 15) == 0);
         ld_bank     = 1'($urandom_range(0, 1));
         ld_valid    = ($urandom_range(0, 1) == 1);
         ld_data     = 9'($urandom);
         ld_last     = ($urandom_range(0, 7) == 0);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
